// File: rtl/bch15_stream_decoder.sv
// Streaming BCH(15,7) t=2 decoder over GF(16): syndromes, Lambda, Chien search
// and correction in a three-stage pipeline with valid/ready on both ends.
module bch15_stream_decoder #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [14:0]        in_word,
    input  logic               in_detect_only,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [14:0]        out_word,
    output logic [6:0]         out_msg,
    output logic [1:0]         out_nerr,
    output logic               out_uncorr,
    input  logic               clr_stats,
    output logic [COUNT_W-1:0] cnt_words,
    output logic [COUNT_W-1:0] cnt_corr,
    output logic [COUNT_W-1:0] cnt_uncorr
);

    localparam int unsigned N_W  = 15;
    localparam int unsigned GF_W = 4;

    // Antilog table: alpha^e for e in 0..14
    function automatic logic [GF_W-1:0] gf_exp(input logic [GF_W-1:0] e);
        logic [GF_W-1:0] r;
        case (e)
            4'd0:  r = 4'h1;
            4'd1:  r = 4'h2;
            4'd2:  r = 4'h4;
            4'd3:  r = 4'h8;
            4'd4:  r = 4'h3;
            4'd5:  r = 4'h6;
            4'd6:  r = 4'hC;
            4'd7:  r = 4'hB;
            4'd8:  r = 4'h5;
            4'd9:  r = 4'hA;
            4'd10: r = 4'h7;
            4'd11: r = 4'hE;
            4'd12: r = 4'hF;
            4'd13: r = 4'hD;
            4'd14: r = 4'h9;
            default: r = 4'h1;
        endcase
        return r;
    endfunction

    // Log table; log(0) returns 0 and is never used on a selected path
    function automatic logic [GF_W-1:0] gf_log(input logic [GF_W-1:0] a);
        logic [GF_W-1:0] r;
        case (a)
            4'h1: r = 4'd0;
            4'h2: r = 4'd1;
            4'h3: r = 4'd4;
            4'h4: r = 4'd2;
            4'h5: r = 4'd8;
            4'h6: r = 4'd5;
            4'h7: r = 4'd10;
            4'h8: r = 4'd3;
            4'h9: r = 4'd14;
            4'hA: r = 4'd9;
            4'hB: r = 4'd7;
            4'hC: r = 4'd6;
            4'hD: r = 4'd13;
            4'hE: r = 4'd11;
            4'hF: r = 4'd12;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a, input logic [GF_W-1:0] b);
        logic [GF_W:0] s;
        s = 5'(gf_log(a)) + 5'(gf_log(b));
        if (s >= 5'd15) s = s - 5'd15;
        return ((a == 4'h0) || (b == 4'h0)) ? 4'h0 : gf_exp(s[GF_W-1:0]);
    endfunction

    function automatic logic [GF_W-1:0] gf_inv(input logic [GF_W-1:0] a);
        logic [GF_W-1:0] l;
        l = gf_log(a);
        return (l == 4'd0) ? 4'h1 : gf_exp(4'd15 - l);
    endfunction

    logic              run_q, run_d;
    logic              s1_valid_q, s1_valid_d, s1_det_q, s1_det_d;
    logic [N_W-1:0]    s1_word_q, s1_word_d;
    logic              s2_valid_q, s2_valid_d, s2_det_q, s2_det_d;
    logic [N_W-1:0]    s2_word_q, s2_word_d;
    logic [GF_W-1:0]   s2_syn1_q, s2_syn1_d, s2_syn3_q, s2_syn3_d, s2_lam2_q, s2_lam2_d;
    logic              out_valid_q, out_valid_d, out_uncorr_q, out_uncorr_d;
    logic [N_W-1:0]    out_word_q, out_word_d;
    logic [1:0]        out_nerr_q, out_nerr_d;
    logic [COUNT_W-1:0] cnt_words_q, cnt_words_d, cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;

    logic [GF_W-1:0]   syn1_c, syn3_c, lam2_c, cube_c;
    logic [N_W-1:0]    roots_c, fix_word_c;
    logic [GF_W-1:0]   nroot_c;
    logic [1:0]        fix_nerr_c;
    logic              fix_uncorr_c, adv_c, hs_c;

    // Stage 1: syndromes S1 = r(alpha), S3 = r(alpha^3) of the registered word
    always_comb begin
        syn1_c = 4'h0;
        syn3_c = 4'h0;
        for (int i = 0; i < 15; i++) begin
            if (s1_word_q[i]) begin
                syn1_c = syn1_c ^ gf_exp(4'(i));
                syn3_c = syn3_c ^ gf_exp(4'((3 * i) % 15));
            end
        end
    end

    // Stage 1: second Lambda coefficient, only meaningful when S1 != 0
    always_comb begin
        lam2_c = 4'h0;
        if (syn1_c != 4'h0) begin
            lam2_c = gf_mul(syn3_c, gf_inv(syn1_c)) ^ gf_mul(syn1_c, syn1_c);
        end
    end

    // Stage 2: Chien search over all 15 positions, classification and correction
    always_comb begin
        roots_c = '0;
        nroot_c = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if ((4'h1 ^ gf_mul(s2_syn1_q, gf_exp(4'((15 - i) % 15)))
                      ^ gf_mul(s2_lam2_q, gf_exp(4'((30 - 2 * i) % 15)))) == 4'h0) begin
                roots_c[i] = 1'b1;
                nroot_c    = nroot_c + 4'd1;
            end
        end
        cube_c       = gf_mul(s2_syn1_q, gf_mul(s2_syn1_q, s2_syn1_q));
        fix_word_c   = s2_word_q;
        fix_nerr_c   = 2'd0;
        fix_uncorr_c = 1'b0;
        if (s2_syn1_q == 4'h0) begin
            fix_uncorr_c = (s2_syn3_q != 4'h0);
        end else if (s2_syn3_q == cube_c) begin
            fix_nerr_c = 2'd1;
            fix_word_c = s2_word_q ^ (15'(1) << gf_log(s2_syn1_q));
        end else if (nroot_c == 4'd2) begin
            fix_nerr_c = 2'd2;
            fix_word_c = s2_word_q ^ roots_c;
        end else begin
            fix_uncorr_c = 1'b1;
        end
        // Uncorrectable or detect-only words pass through unmodified
        if (fix_uncorr_c || s2_det_q) fix_word_c = s2_word_q;
    end

    // Pipeline advance and saturating statistics
    always_comb begin
        adv_c        = run_q & (~out_valid_q | out_ready);
        hs_c         = out_valid_q & out_ready;
        run_d        = 1'b1;
        s1_valid_d   = s1_valid_q;
        s1_word_d    = s1_word_q;
        s1_det_d     = s1_det_q;
        s2_valid_d   = s2_valid_q;
        s2_word_d    = s2_word_q;
        s2_det_d     = s2_det_q;
        s2_syn1_d    = s2_syn1_q;
        s2_syn3_d    = s2_syn3_q;
        s2_lam2_d    = s2_lam2_q;
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        out_nerr_d   = out_nerr_q;
        out_uncorr_d = out_uncorr_q;
        cnt_words_d  = cnt_words_q;
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (adv_c) begin
            s1_valid_d  = in_valid;
            s1_word_d   = in_word;
            s1_det_d    = in_detect_only;
            s2_valid_d  = s1_valid_q;
            s2_word_d   = s1_word_q;
            s2_det_d    = s1_det_q;
            s2_syn1_d   = syn1_c;
            s2_syn3_d   = syn3_c;
            s2_lam2_d   = lam2_c;
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_word_d   = fix_word_c;
                out_nerr_d   = fix_nerr_c;
                out_uncorr_d = fix_uncorr_c;
            end
        end
        if (clr_stats) begin
            cnt_words_d  = '0;
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else begin
            if (hs_c && (cnt_words_q != '1)) cnt_words_d = cnt_words_q + COUNT_W'(1);
            if (hs_c && (out_nerr_q != 2'd0) && !out_uncorr_q && (cnt_corr_q != '1))
                cnt_corr_d = cnt_corr_q + COUNT_W'(1);
            if (hs_c && out_uncorr_q && (cnt_uncorr_q != '1)) cnt_uncorr_d = cnt_uncorr_q + COUNT_W'(1);
        end
    end

    // State registers; reset discards every in-flight word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_word_q    <= '0;
            s1_det_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_word_q    <= '0;
            s2_det_q     <= 1'b0;
            s2_syn1_q    <= '0;
            s2_syn3_q    <= '0;
            s2_lam2_q    <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_nerr_q   <= '0;
            out_uncorr_q <= 1'b0;
            cnt_words_q  <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            run_q        <= run_d;
            s1_valid_q   <= s1_valid_d;
            s1_word_q    <= s1_word_d;
            s1_det_q     <= s1_det_d;
            s2_valid_q   <= s2_valid_d;
            s2_word_q    <= s2_word_d;
            s2_det_q     <= s2_det_d;
            s2_syn1_q    <= s2_syn1_d;
            s2_syn3_q    <= s2_syn3_d;
            s2_lam2_q    <= s2_lam2_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_nerr_q   <= out_nerr_d;
            out_uncorr_q <= out_uncorr_d;
            cnt_words_q  <= cnt_words_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign in_ready   = adv_c;
    assign out_valid  = out_valid_q;
    assign out_word   = out_word_q;
    assign out_msg    = out_word_q[14:8];
    assign out_nerr   = out_nerr_q;
    assign out_uncorr = out_uncorr_q;
    assign cnt_words  = cnt_words_q;
    assign cnt_corr   = cnt_corr_q;
    assign cnt_uncorr = cnt_uncorr_q;

endmodule

// File: tb/tb_bch15_stream_decoder.sv
// Directed bench for bch15_stream_decoder; a second instance with 2-bit
// counters shares the stimulus to observe counter saturation.
module tb_bch15_stream_decoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_detect_only, out_ready, clr_stats;
    logic [14:0] in_word;
    logic        in_ready, out_valid, out_uncorr;
    logic [14:0] out_word;
    logic [6:0]  out_msg;
    logic [1:0]  out_nerr;
    logic [15:0] cnt_words, cnt_corr, cnt_uncorr;
    logic        in_ready_s, out_valid_s, out_uncorr_s;
    logic [14:0] out_word_s;
    logic [6:0]  out_msg_s;
    logic [1:0]  out_nerr_s;
    logic [1:0]  cnt_words_s, cnt_corr_s, cnt_uncorr_s;

    int tests = 0;
    int fails = 0;

    logic [14:0] vin  [16];
    logic [17:0] vexp [16];

    always #5 clk = ~clk;

    bch15_stream_decoder #(.COUNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .in_detect_only(in_detect_only), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_msg(out_msg), .out_nerr(out_nerr), .out_uncorr(out_uncorr),
        .clr_stats(clr_stats), .cnt_words(cnt_words), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    bch15_stream_decoder #(.COUNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_word(in_word),
        .in_detect_only(in_detect_only), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_word(out_word_s), .out_msg(out_msg_s), .out_nerr(out_nerr_s), .out_uncorr(out_uncorr_s),
        .clr_stats(clr_stats), .cnt_words(cnt_words_s), .cnt_corr(cnt_corr_s), .cnt_uncorr(cnt_uncorr_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One word through an idle pipeline: accepted on edge E0, visible after E2, consumed at E3
    task automatic send_one(input string tag, input logic [14:0] w, input logic det,
                            input logic [14:0] ew, input logic [1:0] en, input logic eu,
                            input logic clr_hs);
        in_valid = 1'b1; in_word = w; in_detect_only = det; out_ready = 1'b1;
        #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        #1 check({tag, ".lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #2 check({tag, ".lat2"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1 clr_stats = clr_hs;
        #1 check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".word"},   32'(out_word),   32'(ew));
        check({tag, ".msg"},    32'(out_msg),    32'(ew[14:8]));
        check({tag, ".nerr"},   32'(out_nerr),   32'(en));
        check({tag, ".uncorr"}, 32'(out_uncorr), 32'(eu));
        @(posedge clk); #1 clr_stats = 1'b0;
        #1 check({tag, ".drain"}, 32'(out_valid), 32'd0);
    endtask

    // Stream n words from vin; bp selects random out_ready with a forced 5-cycle stall
    task automatic stream(input string tag, input int n, input bit bp);
        int sent, got, cyc, first, last;
        logic [17:0] prev;
        logic prev_stall;
        sent = 0; got = 0; cyc = 0; first = -1; last = -1; prev = '0; prev_stall = 1'b0;
        in_detect_only = 1'b0;
        while ((got < n) && (cyc < 300)) begin
            in_valid  = (sent < n);
            in_word   = (sent < n) ? vin[sent] : 15'h0;
            out_ready = bp ? (((cyc >= 6) && (cyc < 11)) ? 1'b0 : 1'(($urandom_range(0, 1)))) : 1'b1;
            #1;
            if (prev_stall) begin
                check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, ".hold_out"}, 32'({out_uncorr, out_nerr, out_word}), 32'(prev));
            end
            if (out_valid && !out_ready) check({tag, ".stall_rdy"}, 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                check({tag, ".out"}, 32'({out_uncorr, out_nerr, out_word}), 32'(vexp[got]));
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) sent++;
            prev_stall = out_valid && !out_ready;
            prev = {out_uncorr, out_nerr, out_word};
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check({tag, ".count"}, 32'(got), 32'(n));
        if (!bp) check({tag, ".contig"}, 32'(last - first), 32'(n - 1));
    endtask

    task automatic check_cnt(input string tag, input int w, input int c, input int u,
                             input int ws, input int cs, input int us);
        check({tag, ".cnt_words"},    32'(cnt_words),    32'(w));
        check({tag, ".cnt_corr"},     32'(cnt_corr),     32'(c));
        check({tag, ".cnt_uncorr"},   32'(cnt_uncorr),   32'(u));
        check({tag, ".cnt_words_s"},  32'(cnt_words_s),  32'(ws));
        check({tag, ".cnt_corr_s"},   32'(cnt_corr_s),   32'(cs));
        check({tag, ".cnt_uncorr_s"}, 32'(cnt_uncorr_s), 32'(us));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b0; in_valid = 1'b1; in_word = 15'h7FFF; in_detect_only = 1'b0;
        out_ready = 1'b1; clr_stats = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst.in_ready",   32'(in_ready),   32'd0);
        check("rst.out_valid",  32'(out_valid),  32'd0);
        check("rst.out_word",   32'(out_word),   32'd0);
        check("rst.out_msg",    32'(out_msg),    32'd0);
        check("rst.out_nerr",   32'(out_nerr),   32'd0);
        check("rst.out_uncorr", 32'(out_uncorr), 32'd0);
        check_cnt("rst", 0, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("release.in_ready", 32'(in_ready), 32'd1);

        send_one("clean",  15'h01D1, 1'b0, 15'h01D1, 2'd0, 1'b0, 1'b0);
        check_cnt("clean", 1, 0, 0, 1, 0, 0);
        send_one("single", 15'h0008, 1'b0, 15'h0000, 2'd1, 1'b0, 1'b0);
        send_one("double", 15'h41D5, 1'b0, 15'h01D1, 2'd2, 1'b0, 1'b0);
        send_one("detect", 15'h41D5, 1'b1, 15'h41D5, 2'd2, 1'b0, 1'b0);
        check_cnt("directed", 4, 3, 0, 3, 3, 0);

        clr_stats = 1'b1; @(posedge clk); #1 clr_stats = 1'b0;
        #1 check_cnt("clear", 0, 0, 0, 0, 0, 0);
        send_one("uncorr", 15'h0013, 1'b0, 15'h0013, 2'd0, 1'b1, 1'b0);
        check_cnt("uncorr", 1, 0, 1, 1, 0, 1);
        send_one("clr_prio", 15'h01D1, 1'b0, 15'h01D1, 2'd0, 1'b0, 1'b1);
        check_cnt("clr_prio", 0, 0, 0, 0, 0, 0);

        // All 15 single-bit flips of the message-1 codeword
        for (int i = 0; i < 15; i++) begin
            vin[i]  = 15'h01D1 ^ (15'(1) << i);
            vexp[i] = {1'b0, 2'd1, 15'h01D1};
        end
        stream("burst", 15, 1'b0);
        check_cnt("burst", 15, 15, 0, 3, 3, 0);

        clr_stats = 1'b1; @(posedge clk); #1 clr_stats = 1'b0;
        // Codewords g(x)*x^k and g(x)*(x+1), with zero, one or two flipped bits
        vin[0] = 15'h01D0; vexp[0] = {1'b0, 2'd1, 15'h01D1};
        vin[1] = 15'h03B2; vexp[1] = {1'b0, 2'd1, 15'h03A2};
        vin[2] = 15'h0744; vexp[2] = {1'b0, 2'd0, 15'h0744};
        vin[3] = 15'h4E88; vexp[3] = {1'b0, 2'd1, 15'h0E88};
        vin[4] = 15'h1C10; vexp[4] = {1'b0, 2'd1, 15'h1D10};
        vin[5] = 15'h3A22; vexp[5] = {1'b0, 2'd1, 15'h3A20};
        vin[6] = 15'h7C40; vexp[6] = {1'b0, 2'd1, 15'h7440};
        vin[7] = 15'h4272; vexp[7] = {1'b0, 2'd2, 15'h0273};
        vin[8] = 15'h0000; vexp[8] = {1'b0, 2'd0, 15'h0000};
        vin[9] = 15'h0013; vexp[9] = {1'b1, 2'd0, 15'h0013};
        stream("bp", 10, 1'b1);
        check_cnt("bp", 10, 7, 1, 3, 3, 1);

        // Reset while words sit in stages 1 and 2 and a third is on the input
        out_ready = 1'b1; in_detect_only = 1'b0;
        in_valid = 1'b1; in_word = 15'h01D1;
        @(posedge clk); #1 in_word = 15'h0008;
        @(posedge clk); #1 in_word = 15'h41D5;
        #3 rst = 1'b0; in_valid = 1'b0;
        #1 check("mid.out_valid", 32'(out_valid), 32'd0);
        check("mid.in_ready", 32'(in_ready), 32'd0);
        check_cnt("mid", 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2 check("mid.held", 32'(out_valid), 32'd0);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #2;
            seen = seen | out_valid;
        end
        check("mid.no_output", 32'(seen), 32'd0);
        send_one("post_rst", 15'h0344, 1'b0, 15'h0744, 2'd1, 1'b0, 1'b0);
        check_cnt("post_rst", 1, 1, 0, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bch15_stream_decoder.md
# bch15_stream_decoder

Streaming, pipelined BCH(15,7) t=2 decoder over GF(16) with valid/ready handshakes on both sides. It sits between the channel deframer and the message sink, replacing the single-word combinational syndrome / BM / Chien / corrector chain. It adds:
- uncorrectable-pattern detection,
- an error-count output,
- a per-word detect-only mode,
- saturating statistics counters.

## Interface
- COUNT_W, 16, width of each statistics counter (2..32)
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  input word valid
- in_ready  out  1  decoder accepts the word this cycle
- in_word  in  15  received word; bit i = coefficient of x^i
- in_detect_only  in  1  per-word mode; 1 = report the word, do not correct it
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts the result
- out_word  out  15  corrected word, or the raw word (see Operation)
- out_msg  out  7  out_word[14:8], the systematic message
- out_nerr  out  2  errors corrected or detected: 0, 1 or 2
- out_uncorr  out  1  uncorrectable pattern
- clr_stats  in  1  synchronous clear of all counters
- cnt_words, cnt_corr, cnt_uncorr  out  COUNT_W each  words output, words with out_nerr≠0 and not uncorrectable, words with out_uncorr set

## Operation
- Field: GF(2^4) with primitive polynomial x^4+x+1. Code generator is x^8+x^7+x^6+x^4+1. Systematic form: message in bits [14:8].
- Syndromes: S1 = r(α), S3 = r(α^3). S2 is not needed (S2 = S1^2).
- Classification:
  - S1=0 and S3=0: no error; nerr=0.
  - S1≠0 and S3=S1^3: single error at position log_α(S1); nerr=1.
  - S1≠0 otherwise: Λ(x) = 1 + S1·x + (S3·S1^-1 + S1^2)·x^2.
    - Chien search tests Λ(α^-i)=0 for all i in 0..14.
    - Exactly 2 roots: flip those positions; nerr=2.
    - Any other root count: uncorrectable.
  - S1=0 and S3≠0: uncorrectable.
- Uncorrectable result: out_word = raw input, out_uncorr=1, out_nerr=0.
- Detect-only result: out_word = raw input; out_nerr and out_uncorr are reported as if correcting.
- Arithmetic:
  - GF multiply and inverse are implemented with log/antilog tables or combinational logic.
  - Log arithmetic is mod 15.
  - The inverse of 0 is never used on a selected path.
- Counters:
  - Each counter increments by 1 on every output handshake (out_valid && out_ready) that meets its condition.
  - Counters saturate at 2^COUNT_W−1.
  - clr_stats has priority over an increment in the same cycle: result is 0.

## Timing
- Three-stage pipeline:
  - S1: register the word and mode; compute syndromes.
  - S2: register syndromes and Λ.
  - S3: Chien search and correction into the output register.
- Latency: 3 cycles from an in_valid && in_ready edge to out_valid, when there is no stall.
- Global advance: adv = !out_valid || out_ready. in_ready = adv.
- All stages shift only when adv=1; each stage carries its own valid bit.
- Throughput: 1 word/cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0.
  - Every stage holds.
  - out_* remain stable.
  - in_ready=0; no word is lost or duplicated.
- out_valid stays 1 until it is accepted.
- Bubbles (in_valid=0) propagate as invalid stages and create no output.
- Reset: asynchronous assert, synchronous release. While rst=0 every output is 0:
  - in_ready, out_valid, out_word, out_msg, out_nerr, out_uncorr, and all counters.
  - Exception: in_ready becomes 1 on the first cycle after release.
- Reset mid-stream: all in-flight words are discarded with no output. Counters clear.

## Test plan
- Clean codeword: in_word=15'h01D1 (message 7'h01) → 3 cycles later out_word=15'h01D1, out_msg=7'h01, out_nerr=0, out_uncorr=0.
- Single error: in_word=15'h0008 (zero codeword, bit 3 flipped) → out_word=15'h0000, out_nerr=1. A burst of all 15 single-bit flips of 15'h01D1 on consecutive cycles → 15 consecutive outputs of 15'h01D1.
- Double error: in_word=15'h41D5 → out_word=15'h01D1, out_nerr=2. The same word with in_detect_only=1 → out_word=15'h41D5, out_nerr=2.
- Uncorrectable: in_word=15'h0013 (S1=0, S3=α^2+α) → out_word=15'h0013, out_uncorr=1, out_nerr=0; cnt_uncorr increments by 1.
- Backpressure:
  - Stimulus: 10 back-to-back words while out_ready toggles randomly and is held low for 5 cycles.
  - Required: outputs appear in order, none are lost, in_ready=0 throughout the stall, and out_* are stable while stalled.
  - With COUNT_W=2 and 5 words: cnt_words saturates at 3.
- Reset mid-stream: rst deasserted (driven low) while 3 words are in flight → no output appears, counters read 0, and after release a new word decodes with 3-cycle latency.
